// File: rtl/sonic_pkg.sv
// Shared types and constants for the ultrasonic echo detector.
package sonic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StListen,
        StDone
    } echo_state_t;

    localparam logic [15:0] ADC_MIDPOINT = 16'h8000;

    // Full-wave rectification of an offset-binary sample about the ADC midpoint.
    function automatic logic [15:0] rectify(input logic [15:0] sample);
        return (sample >= ADC_MIDPOINT) ? (sample - ADC_MIDPOINT) : (ADC_MIDPOINT - sample);
    endfunction

endpackage

// File: rtl/envelope_follower.sv
// Rectifier plus leaky-integrator envelope follower.
// clear_in zeroes the envelope; a coincident valid_in is folded into the cleared value.
module envelope_follower
    import sonic_pkg::*;
#(
    parameter int unsigned ENV_SHIFT = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic        clear_in,
    input  logic [15:0] sample_in,
    output logic [15:0] env_out
);

    logic [15:0] env_q, env_d;
    logic [15:0] env_base;
    logic [15:0] rect;

    assign rect     = rectify(sample_in);
    assign env_base = clear_in ? 16'h0000 : env_q;

    // Decay by env >> ENV_SHIFT and add rect >> ENV_SHIFT; the sum can never exceed 16 bits.
    always_comb begin
        env_d = env_base;
        if (valid_in) begin
            env_d = env_base - (env_base >> ENV_SHIFT) + (rect >> ENV_SHIFT);
        end
    end

    // Envelope register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            env_q <= 16'h0000;
        end else begin
            env_q <= env_d;
        end
    end

    assign env_out = env_q;

endmodule

// File: rtl/echo_detector.sv
// Ultrasonic time-of-flight echo detector: blanking, listen window, hold-count detection.
// Optional macro ECHO_PEAK_TRACK_EN builds the peak-envelope tracker; otherwise peak_out is 0.
// HOLD_SAMPLES must be at least 1.
module echo_detector
    import sonic_pkg::*;
#(
    parameter int unsigned BLANK_SAMPLES = 2000,
    parameter int unsigned MAX_SAMPLES   = 35000,
    parameter int unsigned HOLD_SAMPLES  = 4,
    parameter int unsigned ENV_SHIFT     = 3,
    parameter int unsigned TOF_WIDTH     = 24
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [15:0]          sample_in,
    input  logic                 data_valid_in,
    input  logic                 burst_start_in,
    input  logic [15:0]          threshold_in,
    output logic [TOF_WIDTH-1:0] tof_out,
    output logic                 tof_valid_out,
    output logic                 timeout_out,
    output logic [15:0]          peak_out,
    output logic                 busy_out
);

    localparam int unsigned          HoldW    = $clog2(HOLD_SAMPLES + 1);
    localparam logic [TOF_WIDTH-1:0] BlankCnt = TOF_WIDTH'(BLANK_SAMPLES);
    localparam logic [TOF_WIDTH-1:0] MaxCnt   = TOF_WIDTH'(MAX_SAMPLES);
    localparam logic [HoldW-1:0]     HoldCnt  = HoldW'(HOLD_SAMPLES);

    echo_state_t          state_q, state_d;
    logic [TOF_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [HoldW-1:0]     hold_q, hold_d, hold_inc;
    logic [TOF_WIDTH-1:0] cand_q, cand_d;
    logic [15:0]          thr_q, thr_d;
    logic [TOF_WIDTH-1:0] tof_q, tof_d;
    logic                 tof_valid_q, tof_valid_d;
    logic                 timeout_q, timeout_d;
    logic [15:0]          env;
    logic                 env_run;
    logic                 over_thr;

    // A burst-coincident sample is sample 0 of the new window, so it feeds the cleared envelope.
    assign env_run = data_valid_in &&
                     (burst_start_in || (state_q == StBlank) || (state_q == StListen));

    envelope_follower #(
        .ENV_SHIFT (ENV_SHIFT)
    ) u_env (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (env_run),
        .clear_in  (burst_start_in),
        .sample_in (sample_in),
        .env_out   (env)
    );

    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign hold_inc = hold_q + 1'b1;
    assign over_thr = (env >= thr_q);

    // Next-state logic: a burst restarts from any state; detection beats timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        cand_d      = cand_q;
        thr_d       = thr_q;
        tof_d       = tof_q;
        tof_valid_d = 1'b0;
        timeout_d   = 1'b0;
        if (burst_start_in) begin
            state_d = StBlank;
            cnt_d   = data_valid_in ? TOF_WIDTH'(1) : '0;
            hold_d  = '0;
            cand_d  = '0;
            thr_d   = threshold_in;
            tof_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StBlank: begin
                    if (data_valid_in) begin
                        cnt_d = cnt_inc;
                    end
                    if (cnt_d >= BlankCnt) begin
                        state_d = StListen;
                    end
                end
                StListen: begin
                    if (data_valid_in) begin
                        cnt_d = cnt_inc;
                        if (over_thr) begin
                            hold_d = hold_inc;
                            if (hold_q == '0) begin
                                cand_d = cnt_q;
                            end
                        end else begin
                            hold_d = '0;
                        end
                        if (over_thr && (hold_inc == HoldCnt)) begin
                            state_d     = StDone;
                            tof_valid_d = 1'b1;
                            tof_d       = (hold_q == '0) ? cnt_q : cand_q;
                        end else if (cnt_inc >= MaxCnt) begin
                            state_d   = StDone;
                            timeout_d = 1'b1;
                            tof_d     = '1;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hold_q      <= '0;
            cand_q      <= '0;
            thr_q       <= 16'h0000;
            tof_q       <= '0;
            tof_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            cand_q      <= cand_d;
            thr_q       <= thr_d;
            tof_q       <= tof_d;
            tof_valid_q <= tof_valid_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef ECHO_PEAK_TRACK_EN
    logic [15:0] peak_q, peak_d;

    // Peak envelope seen on valid samples in LISTEN; cleared by each burst.
    always_comb begin
        peak_d = peak_q;
        if (burst_start_in) begin
            peak_d = 16'h0000;
        end else if ((state_q == StListen) && data_valid_in && (env > peak_q)) begin
            peak_d = env;
        end
    end

    // Peak register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            peak_q <= 16'h0000;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_out = peak_q;
`else
    assign peak_out = 16'h0000;
`endif

    assign tof_out       = tof_q;
    assign tof_valid_out = tof_valid_q;
    assign timeout_out   = timeout_q;
    assign busy_out      = (state_q != StIdle);

endmodule

// File: tb/tb_echo_detector.sv
// Self-checking bench for echo_detector. Window lengths are scaled down (BLANK 200, MAX 3500)
// so that every scenario fits a short run; sample indices in the table scale accordingly.
module tb_echo_detector;

    localparam int unsigned BLANK = 200;
    localparam int unsigned MAX   = 3500;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned SHIFT = 3;
    localparam int unsigned TW    = 24;
    localparam int          OBS_N = 64;

    typedef struct {
        logic [15:0] thr;
        bit          coinc;      // burst coincident with sample 0
        bit          gap;        // insert invalid cycles carrying junk samples
        int          echo_start;
        int          echo_end;
        logic [15:0] echo_val;
        int          abort_at;   // sample index at which the next burst interrupts (MAX = none)
        bit          exp_hit;    // 1: tof_valid_out expected, 0: timeout_out expected
    } vec_t;

    typedef struct {
        logic [1:0]    kind;     // {tof_valid, timeout}
        logic [TW-1:0] tof;
        logic [15:0]   peak;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [15:0]   sample;
    logic          valid;
    logic          burst;
    logic [15:0]   thr;
    logic [TW-1:0] tof;
    logic          tof_valid;
    logic          timeout;
    logic [15:0]   peak;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse capture written only by the monitor.
    int            obs_wr = 0;
    logic [1:0]    obs_kind [OBS_N];
    logic [TW-1:0] obs_tof  [OBS_N];
    logic [15:0]   obs_peak [OBS_N];

    int   rd = 0;
    exp_t exp_q[$];
    vec_t vecs[8];

    echo_detector #(
        .BLANK_SAMPLES (BLANK),
        .MAX_SAMPLES   (MAX),
        .HOLD_SAMPLES  (HOLD),
        .ENV_SHIFT     (SHIFT),
        .TOF_WIDTH     (TW)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .sample_in      (sample),
        .data_valid_in  (valid),
        .burst_start_in (burst),
        .threshold_in   (thr),
        .tof_out        (tof),
        .tof_valid_out  (tof_valid),
        .timeout_out    (timeout),
        .peak_out       (peak),
        .busy_out       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (tof_valid || timeout) begin
            if (obs_wr < OBS_N) begin
                obs_kind[obs_wr] = {tof_valid, timeout};
                obs_tof[obs_wr]  = tof;
                obs_peak[obs_wr] = peak;
            end
            obs_wr = obs_wr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] t, input bit c, input bit g, input int es,
                                input int ee, input logic [15:0] ev, input int ab, input bit h);
        vec_t v;
        v.thr = t; v.coinc = c; v.gap = g; v.echo_start = es; v.echo_end = ee;
        v.echo_val = ev; v.abort_at = ab; v.exp_hit = h;
        return v;
    endfunction

    function automatic logic [15:0] sample_at(input vec_t v, input int i);
        return (i >= v.echo_start && i < v.echo_end) ? v.echo_val : 16'h8000;
    endfunction

    // Sample-indexed reference: the envelope seen by sample i is built from samples 0..i-1.
    function automatic void model(input vec_t v, output bit hit, output logic [TW-1:0] etof,
                                  output logic [15:0] epk);
        logic [15:0] env;
        logic [15:0] r;
        int          d;
        int          hold;
        int          cand;
        env = 16'h0; hold = 0; cand = 0;
        hit = 1'b0; etof = '1; epk = 16'h0;
        for (int i = 0; i < int'(MAX); i++) begin
            if (i >= int'(BLANK)) begin
                if (env > epk) epk = env;
                if (env >= v.thr) begin
                    if (hold == 0) cand = i;
                    hold++;
                    if (hold == int'(HOLD)) begin
                        hit  = 1'b1;
                        etof = TW'(cand);
                        return;
                    end
                end else begin
                    hold = 0;
                end
            end
            d   = int'(sample_at(v, i)) - 32768;
            r   = 16'((d < 0) ? -d : d);
            env = env - (env >> SHIFT) + (r >> SHIFT);
        end
    endfunction

    // Drive one measurement window; push the expectation, then compare the captured pulse.
    task automatic run_vec(input vec_t v);
        bit            hit;
        logic [TW-1:0] etof;
        logic [15:0]   epk;
        exp_t          e;
        exp_t          got_e;
        int            idx;
        int            cyc;
        int            start;
        int            waitc;
        model(v, hit, etof, epk);
        e.kind = v.exp_hit ? 2'b10 : 2'b01;
        e.tof  = etof;
`ifdef ECHO_PEAK_TRACK_EN
        e.peak = epk;
`else
        e.peak = 16'h0;
`endif
        if (v.abort_at >= int'(MAX)) exp_q.push_back(e);
        start = obs_wr;
        @(posedge clk); #1;
        burst = 1'b1;
        thr   = v.thr;
        if (v.coinc) begin
            valid = 1'b1; sample = sample_at(v, 0); idx = 1;
        end else begin
            valid = 1'b0; sample = 16'hFFFF; idx = 0;
        end
        @(posedge clk); #1;
        burst = 1'b0;
        thr   = 16'($urandom);
        check("busy_after_burst", 32'(busy), 32'd1);
        cyc = 0;
        while (idx < int'(MAX) && idx < v.abort_at && obs_wr == start) begin
            if (v.gap && (cyc % 4 == 3)) begin
                valid = 1'b0; sample = 16'hFFFF;
            end else begin
                valid = 1'b1; sample = sample_at(v, idx); idx++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        valid  = 1'b0;
        sample = 16'h8000;
        if (v.abort_at < int'(MAX)) return;
        waitc = 0;
        while (obs_wr == start && waitc < 16) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("pulse_seen", 32'(obs_wr != start), 32'd1);
        got_e = exp_q.pop_front();
        if (obs_wr != start && rd < OBS_N) begin
            check("pulse_kind", 32'(obs_kind[rd]), 32'(got_e.kind));
            check("tof_value", 32'(obs_tof[rd]), 32'(got_e.tof));
            check("peak_value", 32'(obs_peak[rd]), 32'(got_e.peak));
            rd++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("single_pulse", 32'(obs_wr), 32'(rd));
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t r;
        // thr, coinc, gap, echo_start, echo_end, echo_val, abort_at, exp_hit
        vecs[0] = mk(16'd100,   1'b1, 1'b0, MAX,       MAX,       16'h8000, MAX,       1'b0);
        vecs[1] = mk(16'd1000,  1'b0, 1'b1, 500,       MAX,       16'hC000, MAX,       1'b1);
        vecs[2] = mk(16'd0,     1'b1, 1'b0, MAX,       MAX,       16'h8000, MAX,       1'b1);
        vecs[3] = mk(16'd1000,  1'b1, 1'b0, 0,         BLANK - 48, 16'hFFFF, MAX,      1'b0);
        vecs[4] = mk(16'd3000,  1'b0, 1'b0, 1000,      1002,      16'hE000, MAX,       1'b1);
        vecs[5] = mk(16'd20000, 1'b1, 1'b1, 800,       810,       16'hE000, MAX,       1'b0);
        vecs[6] = mk(16'd1000,  1'b0, 1'b0, MAX,       MAX,       16'h8000, BLANK + 300, 1'b0);
        vecs[7] = mk(16'd1000,  1'b1, 1'b0, 400,       MAX,       16'hC000, MAX,       1'b1);

        rst = 1'b1; sample = 16'h8000; valid = 1'b0; burst = 1'b0; thr = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tof", 32'(tof), 32'd0);
        check("reset_tof_valid", 32'(tof_valid), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        check("reset_peak", 32'(peak), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Threshold 0 gives TOF = BLANK; result holds in IDLE, then async reset clears it.
        run_vec(vecs[2]);
        check("tof_hold_idle", 32'(tof), 32'(BLANK));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async_rst_tof", 32'(tof), 32'd0);
        check("async_rst_busy_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset mid-LISTEN while a loud echo is present.
        r = mk(16'hFFFF, 1'b1, 1'b0, 0, MAX, 16'hC000, BLANK + 20, 1'b0);
        run_vec(r);
        check("busy_mid_listen", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_tof_valid", 32'(tof_valid), 32'd0);
        check("async_rst_timeout", 32'(timeout), 32'd0);
        check("async_rst_peak", 32'(peak), 32'd0);
        check("async_rst_tof_mid", 32'(tof), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("no_pulse_on_release", 32'(obs_wr), 32'(rd));

        // A normal measurement after reset.
        run_vec(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
